// File: rtl/oport_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; stall backpressures the CPU when full.
// The FIFO status outputs are registered copies of the internal occupancy counter.
module oport_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CW           = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          ovf_clr,
  output logic          tx,
  output logic          busy,
  output logic          stall,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          stall_q, stall_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic wr_acc;
  logic pop;
  logic baud_done;

  assign wr_acc    = wr_en && (cnt_q != FULL_CNT);
  assign baud_done = (baud_q == BAUD_LAST);

  // Control state: pointers, occupancy, flags and FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  // Data storage carries no reset; it is only observed after a valid load.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (baud_done) state_d = DATA;
      DATA:  if (baud_done && bit_q == 3'd7) state_d = STOP;
      STOP: begin
        if (baud_done) begin
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    baud_d = baud_q + 1'b1;
    if (state_q == IDLE || state_d != state_q || baud_done) baud_d = '0;

    bit_d = bit_q;
    if (state_q != DATA) bit_d = '0;
    else if (baud_done)  bit_d = bit_q + 3'd1;

    sh_d = sh_q;
    if (pop)                              sh_d = mem_q[rd_ptr_q];
    else if (state_q == DATA && baud_done) sh_d = {1'b0, sh_q[7:1]};

    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;

    cnt_d = cnt_q;
    case ({wr_acc, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A rejected write sets the flag even when a clear arrives in the same cycle.
    overflow_d = overflow_q;
    if (wr_en && !wr_acc) overflow_d = 1'b1;
    else if (ovf_clr)     overflow_d = 1'b0;

    count_d = cnt_q;
    stall_d = (cnt_q == FULL_CNT);
    empty_d = (cnt_q == '0);
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = sh_q[0];
      default: tx = 1'b1;
    endcase
    busy = (state_q != IDLE);
  end

  assign stall    = stall_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_oport_uart_tx.sv
// Bench for oport_uart_tx: directed writes feed an expected-byte queue, and a
// line monitor decodes frames from tx and pops the queue to compare.
module tb_oport_uart_tx;
  localparam int CPB = 4;
  localparam int DEP = 4;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          tx, busy, stall, empty, overflow;
  logic [CW-1:0] count;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_q[$];
  int starts_q[$];

  oport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP), .CW(CW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
    .tx(tx), .busy(busy), .stall(stall), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    #1;
    while (!(empty === 1'b1 && busy === 1'b0 && count === '0) && n < max_cyc) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_chk++;
    if (n >= max_cyc) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy=%0b empty=%0b expected idle within %0d cycles",
               tag, busy, empty, max_cyc);
    end
  endtask

  // Line monitor: decode each 8N1 frame and compare with the next expected byte.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    int st;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && reset === 1'b1 && tx === 1'b0) begin
        st = cyc;
        ok = 1'b1;
        b = 8'h00;
        for (int c = 1; c < CPB; c++) begin
          @(posedge clk); #1;
          if (tx !== 1'b0) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          for (int c = 0; c < CPB; c++) begin
            @(posedge clk); #1;
            if (c == 0) b[i] = tx;
            else if (tx !== b[i]) ok = 1'b0;
          end
        end
        for (int c = 0; c < CPB; c++) begin
          @(posedge clk); #1;
          if (tx !== 1'b1) ok = 1'b0;
        end
        starts_q.push_back(st);
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL frame_unexpected: got %02h expected no frame", b);
        end else begin
          e = exp_q.pop_front();
          if (!ok || b !== e) begin
            n_fail++;
            $display("FAIL frame_data: got %02h (shape_ok=%0b) expected %02h", b, ok, e);
          end
        end
      end
    end
  end

  initial begin
    int bcnt;
    logic [7:0] v6 [10];
    v6 = '{8'h00, 8'hFF, 8'h81, 8'h3C, 8'h12, 8'hE7, 8'h5A, 8'hC0, 8'h07, 8'h99};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: single frame 0x55, latency and busy length
    exp_q.push_back(8'h55);
    write_byte(8'h55);
    chk("t1_empty_at_N", empty, 1);
    @(posedge clk); #1;
    chk("t1_empty_at_N1", empty, 0);
    chk("t1_tx_at_N1", tx, 1);
    @(posedge clk); #1;
    chk("t1_tx_at_N2", tx, 0);
    bcnt = 0;
    while (busy === 1'b1 && bcnt < 200) begin
      bcnt++;
      @(posedge clk); #1;
    end
    chk("t1_busy_len", bcnt, 40);
    chk("t1_count_end", count, 0);
    chk("t1_empty_end", empty, 1);
    wait_idle(100, "t1");

    // Test 2: back-to-back frames
    starts_q.delete();
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    write_byte(8'hA1);
    write_byte(8'hB2);
    write_byte(8'hC3);
    wait_idle(300, "t2");
    chk("t2_frames", starts_q.size(), 3);
    if (starts_q.size() == 3) begin
      chk("t2_gap01", starts_q[1] - starts_q[0], 4 * 10 / 4 * CPB);
      chk("t2_gap12", starts_q[2] - starts_q[1], 10 * CPB);
    end

    // Tests 3 and 4: fill the FIFO behind a running frame, overflow, write at pop edge
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    write_byte(8'h55);
    chk("t3_ovf_before", overflow, 0);
    write_byte(8'h66);
    chk("t3_stall", stall, 1);
    chk("t3_overflow", overflow, 1);
    chk("t3_count_full", count, 4);
    repeat (36) @(posedge clk);
    #1;
    write_byte(8'h77);
    chk("t4_count_at_pop", count, 4);
    chk("t4_tx_new_start", tx, 0);
    chk("t4_overflow_held", overflow, 1);
    wait_idle(400, "t3");
    chk("t3_overflow_after_frames", overflow, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("t3_overflow_cleared", overflow, 0);

    // Test 5: reset mid DATA
    mon_en = 1'b0;
    write_byte(8'hF0);
    repeat (14) @(posedge clk);
    #1;
    chk("t5_tx_before_rst", tx, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_tx", tx, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_empty", empty, 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_post_tx", tx, 1);
    chk("t5_post_busy", busy, 0);
    mon_en = 1'b1;
    exp_q.push_back(8'h0F);
    write_byte(8'h0F);
    wait_idle(100, "t5");

    // Test 6: ten bytes with drain between writes, pointers wrap
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(v6[i]);
      write_byte(v6[i]);
      wait_idle(100, "t6");
    end
    chk("t6_overflow", overflow, 0);

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
